// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 3-sample majority vote, false-start rejection, framing check.
// Define UART_RX_PARITY_EN to receive and check one parity bit between data and stop bits.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_master,
    input  logic                 rst_i,
    input  logic                 tick,
    input  logic                 rx_en,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE) + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync1;
    logic                 sync2;
    logic [2:0]           samp;
    logic [CNT_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 frame_flag;
    logic                 vote;
    logic                 start_edge;
    logic                 mid_start;
    logic                 mid_bit;

    // A start needs a high-to-low transition between ticks, so a held-low line never re-arms.
    assign vote       = (samp[2] & samp[1]) | (samp[2] & samp[0]) | (samp[1] & samp[0]);
    assign start_edge = tick & ~sync2 & samp[0];
    assign mid_start  = tick & (tick_cnt == HALF_CNT);
    assign mid_bit    = tick & (tick_cnt == FULL_CNT);

    always_ff @(posedge clk_master or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (rx_en && start_edge) state_next = START;
            START: if (mid_start) state_next = vote ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (mid_bit && bit_cnt == LAST_BIT) state_next = PARITY;
            PARITY: if (mid_bit) state_next = STOP;
`else
            DATA:  if (mid_bit && bit_cnt == LAST_BIT) state_next = STOP;
`endif
            STOP:  if (mid_bit && bit_cnt == LAST_STOP) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state != IDLE && !rx_en) state_next = IDLE;
    end

    always_ff @(posedge clk_master or negedge rst_i) begin
        if (!rst_i) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            samp       <= 3'b111;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_o     <= '0;
            frame_flag <= 1'b0;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
            if (tick) begin
                samp <= {samp[1:0], sync2};
                if (state == IDLE || mid_start && state == START || tick_cnt == FULL_CNT)
                    tick_cnt <= '0;
                else
                    tick_cnt <= tick_cnt + CNT_W'(1);
            end
            if (state == IDLE || state == START) begin
                bit_cnt <= '0;
            end else if (mid_bit && state == DATA) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
            end else if (mid_bit && state == STOP) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (mid_bit && state == DATA) shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (state == IDLE)                      frame_flag <= 1'b0;
            else if (mid_bit && state == STOP && !vote) frame_flag <= 1'b1;
            // Loaded on the way into DONE so the word is already valid while rx_done is high.
            if (state == STOP && state_next == DONE) data_o <= shreg;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_flag;

    always_ff @(posedge clk_master or negedge rst_i) begin
        if (!rst_i)                                  parity_flag <= 1'b0;
        else if (state == IDLE)                      parity_flag <= 1'b0;
        else if (mid_bit && state == PARITY)
            parity_flag <= vote ^ (^shreg) ^ (PARITY_ODD != 0);
    end

    assign parity_err = rx_done & parity_flag;
`else
    assign parity_err = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign rx_done   = (state == DONE);
    assign frame_err = rx_done & frame_flag;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1 receiver plus a 7-bit, two-stop-bit instance.
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk_master = 1'b0;
    logic       rst_i = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] tdiv = 2'd0;
    logic       rx_en = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;

    logic [7:0] data_a;
    logic       rx_done_a, frame_err_a, parity_err_a, busy_a;
    logic [6:0] data_b;
    logic       rx_done_b, frame_err_b, parity_err_b, busy_b;

    int n_vec = 0;
    int n_err = 0;

    int         done_cnt_a = 0, done_cnt_b = 0;
    logic [7:0] last_data_a = '0;
    logic [6:0] last_data_b = '0;
    logic       last_ferr_a = 1'b0, last_perr_a = 1'b0;
    logic       last_ferr_b = 1'b0, last_perr_b = 1'b0;
    logic       prev_done_a = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    uart_rx_param u_dut_a (
        .clk_master (clk_master),
        .rst_i      (rst_i),
        .tick       (tick),
        .rx_en      (rx_en),
        .rx_i       (rx_a),
        .data_o     (data_a),
        .rx_done    (rx_done_a),
        .frame_err  (frame_err_a),
        .parity_err (parity_err_a),
        .busy       (busy_a)
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_ODD(0)) u_dut_b (
        .clk_master (clk_master),
        .rst_i      (rst_i),
        .tick       (tick),
        .rx_en      (rx_en),
        .rx_i       (rx_b),
        .data_o     (data_b),
        .rx_done    (rx_done_b),
        .frame_err  (frame_err_b),
        .parity_err (parity_err_b),
        .busy       (busy_b)
    );

    always #5 clk_master = ~clk_master;

    always @(posedge clk_master) begin
        tdiv <= tdiv + 2'd1;
        tick <= (tdiv == 2'd2);
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Captures every done pulse and confirms busy has dropped one cycle later.
    always @(negedge clk_master) begin
        if (prev_done_a) check_output("busy_after_done", 32'(busy_a), 32'd0);
        prev_done_a <= rx_done_a;
        if (rx_done_a) begin
            done_cnt_a  <= done_cnt_a + 1;
            last_data_a <= data_a;
            last_ferr_a <= frame_err_a;
            last_perr_a <= parity_err_a;
        end
        if (rx_done_b) begin
            done_cnt_b  <= done_cnt_b + 1;
            last_data_b <= data_b;
            last_ferr_b <= frame_err_b;
            last_perr_b <= parity_err_b;
        end
    end

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(negedge clk_master);
            if (tick) c++;
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
        wait_ticks(16);
    endtask

    task automatic apply_stimulus(input bit sel, input int nbits, input logic [8:0] data,
                                  input logic par_val, input int nstop, input logic [1:0] stops);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
        if (PAR_ON) drive_bit(sel, par_val);
        for (int i = 0; i < nstop; i++) drive_bit(sel, stops[i]);
    endtask

    initial begin
        int exp_done_a;
        int exp_done_b;
        exp_done_a = 0;
        exp_done_b = 0;

        vecs[0] = '{8'hD3, 1'b1, 8'hD3, 1'b0};
        vecs[1] = '{8'hE2, 1'b1, 8'hE2, 1'b0};
        vecs[2] = '{8'hAB, 1'b1, 8'hAB, 1'b0};
        vecs[3] = '{8'h8A, 1'b1, 8'h8A, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 8'h55, 1'b1};

        #2 rst_i = 1'b0;
        repeat (3) @(negedge clk_master);
        check_output("reset_busy", 32'(busy_a), 32'd0);
        check_output("reset_done", 32'(rx_done_a), 32'd0);
        check_output("reset_data", 32'(data_a), 32'd0);
        check_output("reset_ferr", 32'(frame_err_a), 32'd0);
        rst_i = 1'b1;
        wait_ticks(4);

        // Frames follow each other with exactly one stop bit and no idle gap.
        for (int v = 0; v < 5; v++) begin
            apply_stimulus(1'b0, 8, {1'b0, vecs[v].data}, ^vecs[v].data, 1, {1'b1, vecs[v].stop});
            exp_done_a++;
            check_output("frame_done_cnt", 32'(done_cnt_a), 32'(exp_done_a));
            check_output("frame_data", 32'(last_data_a), 32'(vecs[v].exp_data));
            check_output("frame_ferr", 32'(last_ferr_a), 32'(vecs[v].exp_ferr));
            check_output("frame_perr", 32'(last_perr_a), 32'd0);
        end
        rx_a = 1'b1;
        wait_ticks(20);

        rx_a = 1'b0;
        wait_ticks(4);
        check_output("glitch_busy_high", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        wait_ticks(12);
        check_output("glitch_busy_low", 32'(busy_a), 32'd0);
        check_output("glitch_no_done", 32'(done_cnt_a), 32'(exp_done_a));

        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
        check_output("abort_busy_before", 32'(busy_a), 32'd1);
        rx_en = 1'b0;
        @(negedge clk_master);
        check_output("abort_busy", 32'(busy_a), 32'd0);
        wait_ticks(2);
        rx_en = 1'b1;
        wait_ticks(200);
        check_output("abort_no_done", 32'(done_cnt_a), 32'(exp_done_a));
        check_output("abort_data_kept", 32'(data_a), 32'h55);

        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
        rst_i = 1'b0;
        #1;
        check_output("rst_mid_busy", 32'(busy_a), 32'd0);
        check_output("rst_mid_data", 32'(data_a), 32'd0);
        check_output("rst_mid_done", 32'(rx_done_a), 32'd0);
        rx_a = 1'b1;
        repeat (3) @(negedge clk_master);
        rst_i = 1'b1;
        wait_ticks(200);
        check_output("rst_no_done", 32'(done_cnt_a), 32'(exp_done_a));

        apply_stimulus(1'b1, 7, 9'h041, 1'b0, 2, 2'b11);
        exp_done_b++;
        check_output("w7_done_cnt", 32'(done_cnt_b), 32'(exp_done_b));
        check_output("w7_data", 32'(last_data_b), 32'h41);
        check_output("w7_ferr", 32'(last_ferr_b), 32'd0);
        check_output("w7_perr", 32'(last_perr_b), 32'd0);

        apply_stimulus(1'b1, 7, 9'h041, 1'b0, 2, 2'b01);
        exp_done_b++;
        check_output("stop2_done_cnt", 32'(done_cnt_b), 32'(exp_done_b));
        check_output("stop2_data", 32'(last_data_b), 32'h41);
        check_output("stop2_ferr", 32'(last_ferr_b), 32'd1);
        rx_b = 1'b1;
        wait_ticks(20);

`ifdef UART_RX_PARITY_EN
        apply_stimulus(1'b1, 7, 9'h041, 1'b1, 2, 2'b11);
        exp_done_b++;
        check_output("par_done_cnt", 32'(done_cnt_b), 32'(exp_done_b));
        check_output("par_perr", 32'(last_perr_b), 32'd1);
        check_output("par_ferr", 32'(last_ferr_b), 32'd0);
        wait_ticks(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
